// File: rtl/usb_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usb_bus_master_pkg
// Brief   : Shared types and constants for the USB device-core bus master.
//           Holds the FSM state encoding and the CSR register map.
// Revision: 1.0 - initial release
// ============================================================================
package usb_bus_master_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // CSR register map (bus_addr[11] = 0)
    localparam logic [11:0] CSR_CTRL   = 12'h000;
    localparam logic [11:0] CSR_STATUS = 12'h001;
    localparam logic [11:0] CSR_EVT    = 12'h002;

    // bus_addr[11] = 1 selects EP status / buffer descriptors
    localparam int EPS_REGION_BIT = 11;

    // Ack-timeout counter width
    localparam int TMO_W = 16;

    // Cycles irq stays masked after an event fetch finishes on the bus
    localparam logic [1:0] HOLDOFF_CYCLES = 2'd3;

endpackage
`default_nettype wire

// File: rtl/usb_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : usb_bus_master
// Brief   : Single-outstanding initiator for the 16-bit USB core register
//           bus. Serves external requests and irq-driven event fetches with
//           round-robin arbitration, an ack timeout and a one-cycle bus gap.
// Revision: 1.0 - initial release
// ============================================================================
module usb_bus_master
    import usb_bus_master_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter int          EVT_AUTO = 1,
    parameter logic [11:0] EVT_ADDR = CSR_EVT
) (
    input  logic        clk,
    input  logic        rst,
    // request stream
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    input  logic        req_we,
    input  logic [15:0] req_wdata,
    // response stream
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_evt,
    // device core
    input  logic        irq,
    output logic [11:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    output logic        bus_cyc,
    output logic        bus_we,
    input  logic        bus_ack
);

    // Last ACCESS cycle index before the access is declared dead
    localparam logic [TMO_W-1:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    localparam logic             EVT_EN   = (EVT_AUTO != 0);

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       holdoff;
    logic             prefer_evt;   // 1: event fetch wins the next contention
    logic             cur_evt;      // in-flight access is an event fetch

    logic evt_pending;
    logic grant_evt;
    logic grant_ext;
    logic timeout_hit;

    // Arbiter: decide which source (if any) starts an access this cycle
    always_comb begin
        evt_pending = EVT_EN && irq && (holdoff == 2'd0);
        grant_evt   = 1'b0;
        grant_ext   = 1'b0;
        if (state == ST_IDLE && !rsp_valid) begin
            if (evt_pending && (!req_valid || prefer_evt)) begin
                grant_evt = 1'b1;
            end else if (req_valid) begin
                grant_ext = 1'b1;
            end
        end
    end

    assign req_ready   = grant_ext;
    assign timeout_hit = (tmo_cnt >= TMO_LAST);

    // Transaction sequencer with registered bus and response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            tmo_cnt    <= '0;
            holdoff    <= 2'd0;
            prefer_evt <= 1'b1;
            cur_evt    <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_cyc    <= 1'b0;
            bus_we     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            rsp_evt    <= 1'b0;
        end else begin
            if (holdoff != 2'd0) begin
                holdoff <= holdoff - 2'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (grant_evt) begin
                        bus_addr   <= EVT_ADDR;
                        bus_we     <= 1'b0;
                        bus_wdata  <= '0;
                        bus_cyc    <= 1'b1;
                        cur_evt    <= 1'b1;
                        prefer_evt <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= ST_ACCESS;
                    end else if (grant_ext) begin
                        bus_addr   <= req_addr;
                        bus_we     <= req_we;
                        bus_wdata  <= req_wdata;
                        bus_cyc    <= 1'b1;
                        cur_evt    <= 1'b0;
                        prefer_evt <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    // An ack on the timeout cycle still counts as success
                    if (bus_ack || timeout_hit) begin
                        rsp_rdata <= (bus_ack && !bus_we) ? bus_rdata : 16'h0000;
                        rsp_err   <= !bus_ack;
                        rsp_evt   <= cur_evt;
                        bus_cyc   <= 1'b0;
                        bus_we    <= 1'b0;
                        if (cur_evt) begin
                            holdoff <= HOLDOFF_CYCLES;
                        end
                        state     <= ST_GAP;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                ST_GAP: begin
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_usb_bus_master
// Brief   : Self-checking bench for usb_bus_master: directed scenarios plus
//           randomized traffic against a transaction-level scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_usb_bus_master;

    localparam int          TMO      = 8;
    localparam logic [11:0] EVT_A    = 12'h002;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic        req_we;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_evt;
    logic        irq;
    logic [11:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_cyc;
    logic        bus_we;
    logic        bus_ack;

    usb_bus_master #(
        .TIMEOUT  (TMO),
        .EVT_AUTO (1),
        .EVT_ADDR (EVT_A)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_evt   (rsp_evt),
        .irq       (irq),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_cyc   (bus_cyc),
        .bus_we    (bus_we),
        .bus_ack   (bus_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- slave model: acks after slave_delay wait cycles -------
    int          slave_delay = 0;   // -1: never ack
    logic [15:0] slave_data  = 16'h0;
    int          waited;

    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 16'h0;
        waited    = 0;
        forever begin
            @(posedge clk); #1;
            if (!bus_cyc) begin
                waited    = 0;
                bus_ack   = 1'b0;
                bus_rdata = 16'($urandom);
            end else begin
                bus_ack   = (slave_delay >= 0) && (waited == slave_delay);
                bus_rdata = bus_ack ? slave_data : 16'($urandom);
                waited++;
            end
        end
    end

    // ---------------- transaction scoreboard --------------------------------
    logic        prev_cyc, prev_hs, prev_irq, prev_rsp_valid;
    logic [11:0] hs_addr;
    logic        hs_we;
    logic [15:0] hs_wdata;
    logic [11:0] exp_addr;
    logic        exp_we;
    logic [15:0] exp_wdata;
    logic        exp_evt_src;
    int          cur_delay;
    logic [15:0] cur_data;
    int          cyc_len;
    logic        rsp_due, rsp_out;
    logic [15:0] exp_rdata;
    logic        exp_err, exp_evt;
    int          n_starts = 0;
    int          n_rsp    = 0;
    bit          src_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            prev_cyc = 0; prev_hs = 0; prev_irq = 0; prev_rsp_valid = 0;
            rsp_due = 0; rsp_out = 0; cyc_len = 0;
        end else begin
            if (rsp_due) begin
                rsp_out = 1;
                rsp_due = 0;
                n_rsp++;
            end
            if (rsp_out) begin
                chk_eq("rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_evt},
                       {1'b1, exp_rdata, exp_err, exp_evt});
                if (rsp_valid && rsp_ready) rsp_out = 0;
            end else begin
                chk_eq("rsp_spurious", {31'd0, rsp_valid}, 0);
            end

            if (bus_cyc && !prev_cyc) begin
                n_starts++;
                chk_eq("grant_rsp_idle", {31'd0, prev_rsp_valid}, 0);
                exp_evt_src = !prev_hs;
                src_q.push_back(exp_evt_src);
                if (prev_hs) begin
                    exp_addr = hs_addr; exp_we = hs_we; exp_wdata = hs_wdata;
                end else begin
                    exp_addr = EVT_A; exp_we = 1'b0; exp_wdata = 16'h0;
                    chk_eq("evt_needs_irq", {31'd0, prev_irq}, 1);
                end
                cur_delay = slave_delay;
                cur_data  = slave_data;
                cyc_len   = 0;
            end
            if (bus_cyc) begin
                cyc_len++;
                chk_eq("bus_fields", {bus_addr, bus_we}, {exp_addr, exp_we});
                if (!exp_evt_src) chk_eq("bus_wdata", bus_wdata, exp_wdata);
            end
            if (!bus_cyc && prev_cyc) begin
                automatic bit acked = (cur_delay >= 0) && (cur_delay < TMO);
                chk_eq("cyc_len", cyc_len, acked ? cur_delay + 1 : TMO);
                chk_eq("gap_no_rsp", {31'd0, rsp_valid}, 0);
                exp_rdata = (acked && !exp_we) ? cur_data : 16'h0;
                exp_err   = !acked;
                exp_evt   = exp_evt_src;
                rsp_due   = 1;
            end

            prev_hs        = req_valid && req_ready;
            hs_addr        = req_addr;
            hs_we          = req_we;
            hs_wdata       = req_wdata;
            prev_irq       = irq;
            prev_cyc       = bus_cyc;
            prev_rsp_valid = rsp_valid;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // Issue one external request and measure accept-to-response latency
    task automatic run_req(input logic [11:0] a, input logic we, input logic [15:0] wd,
                           input int dly, input logic [15:0] rd);
        int   lat;
        logic hs_seen;
        logic got;
        slave_delay = dly;
        slave_data  = rd;
        req_addr = a; req_we = we; req_wdata = wd; req_valid = 1'b1;
        hs_seen = 1'b0;
        for (int i = 0; i < 40 && !hs_seen; i++) begin
            @(negedge clk);
            hs_seen = req_ready;
            tick();
        end
        req_valid = 1'b0;
        chk_eq("accept", {31'd0, hs_seen}, 1);
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (rsp_valid) got = 1'b1;
            else begin tick(); lat++; end
        end
        chk_eq("rsp_seen", {31'd0, got}, 1);
        chk_eq("latency", lat, ((dly >= 0 && dly < TMO) ? dly + 1 : TMO) + 2);
        tick();
    endtask

    // ---------------- main sequence -----------------------------------------
    initial begin
        int   starts0, rsp0;
        logic got;
        logic any_bad;

        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0;
        rsp_ready = 1'b1; irq = 1'b0;
        repeat (3) tick();
        chk_eq("reset_out", {req_ready, rsp_valid, bus_cyc, bus_we, rsp_err, rsp_evt}, 0);
        chk_eq("reset_data", {bus_addr, rsp_rdata}, 0);
        rst = 1'b1;
        tick();

        // Write, ack in first ACCESS cycle
        run_req(12'h000, 1'b1, 16'h8080, 0, 16'h1234);
        // EP status read, 4 wait cycles
        run_req(12'h805, 1'b0, 16'h0000, 4, 16'hBEEF);
        // No ack at all: timeout
        run_req(12'h001, 1'b0, 16'h0000, -1, 16'h5555);
        // Ack on the very cycle the timeout fires
        run_req(12'h010, 1'b0, 16'h0000, TMO - 1, 16'hA5A5);
        // Ack one cycle too late: timeout
        run_req(12'h011, 1'b0, 16'h0000, TMO, 16'h5A5A);

        // Event fetch with irq held after ack
        starts0 = n_starts; rsp0 = n_rsp;
        slave_delay = 0; slave_data = 16'h1042; irq = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus_cyc) got = 1'b1; else tick();
        end
        chk_eq("evt_started", {31'd0, got}, 1);
        tick();                         // ack edge
        repeat (3) tick();              // irq stays high through GAP, RESP, IDLE
        irq = 1'b0;
        repeat (10) tick();
        chk_eq("evt_fetch_count", n_starts - starts0, 1);
        chk_eq("evt_rsp_count", n_rsp - rsp0, 1);

        // Contention from a fresh reset: event, external, event
        irq = 1'b1; req_valid = 1'b1; req_addr = 12'h001; req_we = 1'b0; req_wdata = 16'h0;
        slave_delay = 1; slave_data = 16'h7E57;
        do_reset();
        src_q.delete();
        for (int i = 0; i < 60 && src_q.size() < 3; i++) tick();
        chk_eq("arb_count", src_q.size(), 3);
        rsp_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (rsp_valid) got = 1'b1; else tick();
        end
        chk_eq("stall_rsp_seen", {31'd0, got}, 1);
        starts0 = n_starts;
        any_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus_cyc || req_ready) any_bad = 1'b1;
            tick();
        end
        chk_eq("stall_no_issue", {31'd0, any_bad}, 0);
        chk_eq("stall_starts", n_starts - starts0, 0);
        rsp_ready = 1'b1; irq = 1'b0; req_valid = 1'b0;
        repeat (10) tick();
        chk_eq("arb_0", {31'd0, src_q[0]}, 1);
        chk_eq("arb_1", {31'd0, src_q[1]}, 0);
        chk_eq("arb_2", {31'd0, src_q[2]}, 1);

        // Reset in the middle of ACCESS
        slave_delay = -1;
        req_addr = 12'h003; req_we = 1'b1; req_wdata = 16'hCAFE; req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus_cyc) got = 1'b1; else tick();
        end
        req_valid = 1'b0;
        repeat (3) tick();
        chk_eq("rst_pre_cyc", {31'd0, bus_cyc}, 1);
        rsp0 = n_rsp;
        rst = 1'b0;
        #1;
        chk_eq("rst_async_cyc", {31'd0, bus_cyc}, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        any_bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid) any_bad = 1'b1;
        end
        chk_eq("rst_no_rsp", {31'd0, any_bad}, 0);
        chk_eq("rst_rsp_count", n_rsp - rsp0, 0);
        run_req(12'h804, 1'b0, 16'h0000, 2, 16'h0F0F);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!bus_cyc) begin
                slave_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 10));
                slave_data  = 16'($urandom);
            end
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = 12'($urandom);
            req_we    = 1'($urandom);
            req_wdata = 16'($urandom);
            irq       = ($urandom_range(0, 3) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 1'b0; irq = 1'b0; rsp_ready = 1'b1;
        repeat (40) tick();
        chk_eq("drain_idle", {30'd0, bus_cyc, rsp_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
